// File: rtl/async_mem_pkg.sv
// Shared types and constants for the Wishbone-to-async-static-memory initiator.
package async_mem_pkg;

  localparam int WST_W  = 5;
  localparam int IDCY_W = 4;
  localparam int BL     = 4;
  localparam int CNT_W  = WST_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4
  } state_e;

  // Levels driven onto the memory bus whenever no access is in progress.
  localparam logic          CS_N_IDLE  = 1'b1;
  localparam logic          OE_N_IDLE  = 1'b1;
  localparam logic          WE_N_IDLE  = 1'b1;
  localparam logic [BL-1:0] BLS_N_IDLE = 4'hF;

  function automatic logic bus_active(input state_e s);
    return (s == SETUP) || (s == STROBE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/async_mem_wait_cnt.sv
// Loadable down-counter with a zero flag; times both the strobe and turnaround phases.
module async_mem_wait_cnt #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/wb_async_mem_initiator.sv
// Wishbone slave that turns each request into one access on a 32-bit async static-memory bus
// with run-time programmable wait states and turnaround.
module wb_async_mem_initiator
  import async_mem_pkg::*;
#(
  parameter int AW = 24,
  parameter int DW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  input  logic [BL-1:0] wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic          wb_ack_o,
  input  logic [IDCY_W-1:0] idcy_i,
  input  logic [WST_W-1:0]  wst1_i,
  input  logic [WST_W-1:0]  wst2_i,
  output logic [AW-1:0] mem_a_o,
  input  logic [DW-1:0] mem_d_i,
  output logic [DW-1:0] mem_d_o,
  output logic          mem_d_oe,
  output logic          mem_cs_n,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  output logic [BL-1:0] mem_bls_n
);

  state_e state_q, state_d;

  logic [AW-1:0]     mem_a_q;
  logic [DW-1:0]     mem_d_q;
  logic [DW-1:0]     dat_o_q;
  logic [BL-1:0]     sel_q;
  logic              we_q;
  logic [WST_W-1:0]  wst1_q, wst2_q;
  logic [IDCY_W-1:0] idcy_q;
  logic              abort_q, abort_d;
  logic              ack_q, ack_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [BL-1:0]     bls_n_q, bls_n_d;
  logic              d_oe_q, d_oe_d;

  logic              accept_s;
  logic              we_eff_s;
  logic              cap_s;
  logic              cnt_load_s;
  logic [CNT_W-1:0]  cnt_val_s;
  logic              cnt_zero_s;
  logic [IDCY_W-1:0] idcy_m1_s;

  assign accept_s  = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
  // Direction is needed one cycle before it is registered, to drive SETUP outputs.
  assign we_eff_s  = accept_s ? wb_we_i : we_q;
  assign cap_s     = (state_q == STROBE) && cnt_zero_s && !we_q;
  assign idcy_m1_s = idcy_q - {{(IDCY_W-1){1'b0}}, 1'b1};

  async_mem_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk_i      (wb_clk_i),
    .rst_n_i    (wb_rst_n_i),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state logic and phase-counter loading.
  always_comb begin
    state_d    = state_q;
    cnt_load_s = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) state_d = SETUP;
        else                      state_d = IDLE;
      end
      SETUP: begin
        state_d    = STROBE;
        cnt_load_s = 1'b1;
        cnt_val_s  = we_q ? wst2_q : wst1_q;
      end
      STROBE: begin
        if (cnt_zero_s) state_d = HOLD;
        else            state_d = STROBE;
      end
      HOLD: begin
        if (idcy_q == {IDCY_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          state_d    = TURN;
          cnt_load_s = 1'b1;
          cnt_val_s  = {{(CNT_W-IDCY_W){1'b0}}, idcy_m1_s};
        end
      end
      TURN: begin
        if (cnt_zero_s) state_d = IDLE;
        else            state_d = TURN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the pins come straight from flops.
  always_comb begin
    cs_n_d  = bus_active(state_d) ? 1'b0 : CS_N_IDLE;
    oe_n_d  = ((state_d == STROBE) && !we_eff_s) ? 1'b0 : OE_N_IDLE;
    we_n_d  = ((state_d == STROBE) && we_eff_s) ? 1'b0 : WE_N_IDLE;
    bls_n_d = ((state_d == STROBE) && we_eff_s) ? ~sel_q : BLS_N_IDLE;
    d_oe_d  = bus_active(state_d) && we_eff_s;
    ack_d   = (state_q == STROBE) && cnt_zero_s && !abort_q && wb_cyc_i;
    if (accept_s) begin
      abort_d = 1'b0;
    end else if (((state_q == SETUP) || (state_q == STROBE)) && !wb_cyc_i) begin
      abort_d = 1'b1;
    end else begin
      abort_d = abort_q;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered memory-bus controls and Wishbone handshake.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cs_n_q  <= CS_N_IDLE;
      oe_n_q  <= OE_N_IDLE;
      we_n_q  <= WE_N_IDLE;
      bls_n_q <= BLS_N_IDLE;
      d_oe_q  <= 1'b0;
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      bls_n_q <= bls_n_d;
      d_oe_q  <= d_oe_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
    end
  end

  // Request capture and read-data capture; timing is frozen for the whole access.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      mem_a_q <= {AW{1'b0}};
      mem_d_q <= {DW{1'b0}};
      dat_o_q <= {DW{1'b0}};
      sel_q   <= {BL{1'b0}};
      we_q    <= 1'b0;
      wst1_q  <= {WST_W{1'b0}};
      wst2_q  <= {WST_W{1'b0}};
      idcy_q  <= {IDCY_W{1'b0}};
    end else begin
      if (accept_s) begin
        mem_a_q <= wb_adr_i;
        sel_q   <= wb_sel_i;
        we_q    <= wb_we_i;
        wst1_q  <= wst1_i;
        wst2_q  <= wst2_i;
        idcy_q  <= idcy_i;
        if (wb_we_i) mem_d_q <= wb_dat_i;
        else         mem_d_q <= mem_d_q;
      end else begin
        mem_a_q <= mem_a_q;
      end
      if (cap_s) dat_o_q <= mem_d_i;
      else       dat_o_q <= dat_o_q;
    end
  end

  assign mem_a_o   = mem_a_q;
  assign mem_d_o   = mem_d_q;
  assign mem_d_oe  = d_oe_q;
  assign mem_cs_n  = cs_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_bls_n = bls_n_q;
  assign wb_dat_o  = dat_o_q;
  assign wb_ack_o  = ack_q;

endmodule

// File: doc/wb_async_mem_initiator.md
Name: wb_async_mem_initiator

Overview:
- Wishbone slave that runs each transfer as one access on a 32-bit asynchronous static-memory bus.
- Bus signals: chip select, output enable, write enable, byte-lane strobes.
- Access timing is run-time programmable: separate read and write wait states plus bus-turnaround idle cycles.
- It is the initiator end of the async memory bus, for the path where on-chip Wishbone masters reach off-chip async peripherals or a companion board over GPIO.
- Bidirectional pins are resolved at top level from mem_d_o/mem_d_oe.

Parameters:
AW, 24, memory address width (byte address, passed through unchanged)
DW, 32, data width; fixed at 32, with 4 byte lanes

Ports:
wb_clk_i  in  1  system clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
wb_adr_i  in  AW  Wishbone byte address
wb_dat_i  in  32  Wishbone write data
wb_dat_o  out  32  Wishbone read data
wb_sel_i  in  4  byte selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  acknowledge
idcy_i  in  4  idle/turnaround cycles after each access
wst1_i  in  5  read wait states
wst2_i  in  5  write wait states
mem_a_o  out  AW  memory address
mem_d_i  in  32  memory data in
mem_d_o  out  32  memory data out
mem_d_oe  out  1  data output enable (1 = FPGA drives the data bus)
mem_cs_n  out  1  chip select
mem_oe_n  out  1  output enable
mem_we_n  out  1  write enable
mem_bls_n  out  4  byte-lane strobes

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset is asynchronous and active-low on wb_rst_n_i.
- Reset values:
  - State IDLE.
  - mem_cs_n, mem_oe_n, mem_we_n = 1; mem_bls_n = 4'hF; mem_d_oe = 0.
  - mem_a_o = 0, mem_d_o = 0, wb_dat_o = 0, wb_ack_o = 0.
- Reset asserted mid-access: the bus returns to idle immediately, with no ack.
- IDLE: on wb_cyc_i & wb_stb_i, register wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i and the timing inputs. The captured timing is held for the whole access; later changes to timing inputs do not affect it. Next state SETUP.
- SETUP (1 cycle):
  - mem_cs_n = 0, mem_a_o valid.
  - Write: mem_d_oe = 1 and mem_d_o = data.
- STROBE (N+1 cycles, N = wst1 for reads, wst2 for writes; counter loads N and counts down to 0):
  - Read: mem_oe_n = 0, mem_bls_n = 4'hF. Read data is selected by wb_sel on the Wishbone side.
  - Write: mem_we_n = 0, mem_bls_n = ~sel.
  - Read: mem_d_i is captured into wb_dat_o on the last STROBE cycle (counter == 0).
- HOLD (1 cycle):
  - oe/we/bls deasserted; cs, address and write data held.
  - wb_ack_o = 1 for exactly this one cycle, unless the access was aborted.
- TURN:
  - cs_n = 1, mem_d_oe = 0, for idcy cycles. idcy = 0 skips TURN and goes straight to IDLE.
  - Requests are not accepted until IDLE, so back-to-back accesses are separated by at least idcy+1 cycles of cs_n high.
- Latency: with stb sampled at edge 0, ack is high in cycle N+3. Read with wst1 = 0: ack in cycle 3.
- Read data: wb_dat_o holds its value until the next read capture; writes do not modify it.
- Abort: wb_cyc_i low during SETUP or STROBE.
  - The memory cycle completes unchanged; the bus is never truncated mid-strobe.
  - The ack in HOLD is suppressed and the FSM continues to TURN/IDLE.
  - wb_dat_o is still updated on an aborted read.
- No error or retry response; every accepted request completes.
- Address is not re-aligned; mem_a_o = wb_adr_i[AW-1:0].
- Outputs mem_* are all registered (glitch-free).

Decomposition:
- Package async_mem_pkg:
  - State enum: IDLE, SETUP, STROBE, HOLD, TURN.
  - Constants WST_W = 5, IDCY_W = 4, BL = 4.
  - Idle-bus output constants (cs/oe/we = 1, bls = 4'hF).
- Sub-module async_mem_wait_cnt: loadable down-counter with a zero flag, used for both STROBE and TURN.

Test Plan:
- Read, wst1 = 0, idcy = 0, mem_d_i = 32'hDEADBEEF at address 24'h012344 -> mem_a_o = 24'h012344; oe_n low exactly 1 cycle; ack in cycle 3; wb_dat_o = DEADBEEF; cs_n low exactly 3 cycles.
- Read, wst1 = 3, mem_d_i changes from 32'h11111111 to 32'hCAFEF00D on the 4th STROBE cycle -> oe_n low 4 cycles; wb_dat_o = CAFEF00D; ack in cycle 6.
- Write, wst2 = 2, sel = 4'b0011, dat = 32'hA5A5_5A5A -> we_n low 3 cycles; bls_n = 4'b1100 only during those cycles; mem_d_oe high from SETUP through HOLD; one-cycle ack.
- Back-to-back reads, idcy = 2, stb held high -> cs_n high exactly 3 cycles between accesses; two acks.
- wb_cyc_i dropped during the 2nd STROBE cycle (wst1 = 3) -> oe_n still low 4 cycles; no ack; FSM returns to IDLE.
- wb_rst_n_i pulsed low mid-STROBE on a write -> same cycle: cs_n = we_n = 1, bls_n = F, mem_d_oe = 0; after release, a new read completes normally.
